// File: rtl/clock_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clock_seq_pkg : mode/state encodings and rate-limit helper for clock_sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
package clock_seq_pkg;

  localparam int PRESC_W = 24;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_SLOW   = 2'b01;
  localparam logic [1:0] MODE_FAST   = 2'b10;
  localparam logic [1:0] MODE_MAX    = 2'b11;

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    BURST  = 2'd2
  } state_e;

  // Prescaler terminal value; the rate period is this value plus one.
  function automatic logic [PRESC_W-1:0] rate_limit(input logic [1:0] mode,
                                                    input logic [7:0] limit);
    if (mode == MODE_SLOW) return {limit, 16'h0000};
    return {16'h0000, limit};
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clock_sequencer_if : run-control bus between board/debug controls and sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
interface clock_sequencer_if #(
  parameter int BURST_W = 16
);

  logic [1:0]         iMode;
  logic [7:0]         iLimit;
  logic               iStep;
  logic               iRun;
  logic               iBurst;
  logic [BURST_W-1:0] iBurstLen;
  logic               iHalt;
  logic               iBreak;
  logic               oTick;
  logic               oRunning;
  logic               oDone;
  logic [31:0]        oTickCount;

  modport master (
    output iMode, iLimit, iStep, iRun, iBurst, iBurstLen, iHalt, iBreak,
    input  oTick, oRunning, oDone, oTickCount
  );

  modport slave (
    input  iMode, iLimit, iStep, iRun, iBurst, iBurstLen, iHalt, iBreak,
    output oTick, oRunning, oDone, oTickCount
  );

endinterface
`default_nettype wire

// File: rtl/step_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// step_conditioner : synchronizes the manual step button and emits a one-cycle
// pulse per press. Optional debounce under STEP_DEBOUNCE_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module step_conditioner #(
  parameter int SYNC_STAGES = 2
`ifdef STEP_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 65536
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic step_i,
  output logic step_pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   step_level;
  logic                   prev_q;
  logic                   pulse_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], step_i};
  end

`ifdef STEP_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_cnt_q;
  logic            db_level_q;

  // The debounced level only follows the synchronized input after it has
  // held its new value for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1] == db_level_q) begin
      db_cnt_q   <= '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt_q   <= '0;
      db_level_q <= sync_q[SYNC_STAGES-1];
    end else begin
      db_cnt_q   <= db_cnt_q + 1'b1;
    end
  end

  assign step_level = db_level_q;
`else
  assign step_level = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= step_level;
      pulse_q <= step_level & ~prev_q;
    end
  end

  assign step_pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/clock_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clock_sequencer : CPU clock-enable generator with halt/run/burst/step control.
// Optional step debounce under STEP_DEBOUNCE_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module clock_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int BURST_W     = 16
`ifdef STEP_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 65536
`endif
) (
  input  logic              iClock,
  input  logic              iReset,
  clock_sequencer_if.slave  ctl
);

  import clock_seq_pkg::*;

  logic [1:0]         mode_q;
  logic [7:0]         limit_q;
  logic               cfg_chg_q;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] lim;
  state_e             state_q, state_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic               running_q;
  logic               done_q, done_now;
  logic               done_pend_q, done_pend_d;
  logic [31:0]        tick_count_q;
  logic               step_pulse;
  logic               rate_tick;
  logic               tick_src;
  logic               halt_req;
  logic               counting;

  step_conditioner #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef STEP_DEBOUNCE_EN
    , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
  ) u_step (
    .clk_i        (iClock),
    .rst_i        (iReset),
    .step_i       (ctl.iStep),
    .step_pulse_o (step_pulse)
  );

  assign lim      = rate_limit(mode_q, limit_q);
  assign halt_req = ctl.iHalt | ctl.iBreak;
  assign counting = (state_q != HALTED) && !cfg_chg_q &&
                    ((mode_q == MODE_SLOW) || (mode_q == MODE_FAST));

  // A freshly changed mode/limit never produces a rate tick in its first cycle.
  always_comb begin
    rate_tick = 1'b0;
    if (!cfg_chg_q) begin
      case (mode_q)
        MODE_MAX:             rate_tick = 1'b1;
        MODE_SLOW, MODE_FAST: rate_tick = (presc_q == lim);
        default:              rate_tick = 1'b0;
      endcase
    end
  end

  always_comb begin
    presc_d = '0;
    if (counting && (presc_q != lim)) presc_d = presc_q + 1'b1;
  end

  assign tick_src = ((state_q == HALTED) || (mode_q == MODE_MANUAL)) ? step_pulse : rate_tick;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tick_d      = 1'b0;
    done_now    = 1'b0;
    done_pend_d = 1'b0;
    if (halt_req) begin
      // Stepping off a breakpoint stays possible while halted.
      state_d = HALTED;
      cnt_d   = '0;
      tick_d  = (state_q == HALTED) && step_pulse;
    end else if (ctl.iBurst) begin
      cnt_d = ctl.iBurstLen;
      if (ctl.iBurstLen == '0) begin
        state_d  = HALTED;
        done_now = 1'b1;
      end else begin
        state_d  = BURST;
      end
    end else if (ctl.iRun && (state_q != RUN)) begin
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      tick_d = tick_src;
      if (tick_src && (state_q == BURST)) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == BURST_W'(1)) begin
          state_d     = HALTED;
          done_pend_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      mode_q       <= MODE_MANUAL;
      limit_q      <= '0;
      cfg_chg_q    <= 1'b0;
      presc_q      <= '0;
      state_q      <= HALTED;
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      done_pend_q  <= 1'b0;
      tick_count_q <= '0;
    end else begin
      mode_q       <= ctl.iMode;
      limit_q      <= ctl.iLimit;
      cfg_chg_q    <= (ctl.iMode != mode_q) || (ctl.iLimit != limit_q);
      presc_q      <= presc_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      running_q    <= (state_d != HALTED);
      done_q       <= done_now | done_pend_q;
      done_pend_q  <= done_pend_d;
      tick_count_q <= tick_count_q + {31'b0, tick_d};
    end
  end

  assign ctl.oTick      = tick_q;
  assign ctl.oRunning   = running_q;
  assign ctl.oDone      = done_q;
  assign ctl.oTickCount = tick_count_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_clock_sequencer : directed and random run-control scenarios against a
// cycle-level behavioural model of the sequencer rules.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_clock_sequencer;

  localparam int SYNC = 2;
  localparam int BW   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clock_sequencer_if #(.BURST_W(BW)) ctl ();

  clock_sequencer #(.SYNC_STAGES(SYNC), .BURST_W(BW)) dut (
    .iClock (clk),
    .iReset (rst),
    .ctl    (ctl)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: run/burst flags, ticks left, elapsed counting phase.
  bit [1:0]  m_mode;
  bit [7:0]  m_lim;
  bit        m_chg;
  longint    m_phase;
  bit        m_run, m_bst;
  int        m_left;
  bit        m_tick, m_done, m_dpend, m_running;
  bit [31:0] m_count;
  bit        sh[$];

  function automatic void model_edge();
    longint lim;
    bit halted, spulse, rate, src, tk, dnow, dpend_n, n_run, n_bst;
    if (rst) begin
      m_mode = 0; m_lim = 0; m_chg = 0; m_phase = 0; m_run = 0; m_bst = 0; m_left = 0;
      m_tick = 0; m_done = 0; m_dpend = 0; m_running = 0; m_count = 0;
      sh.delete();
      for (int i = 0; i < 8; i++) sh.push_back(1'b0);
      return;
    end
    halted = !m_run && !m_bst;
    lim    = (m_mode == 2'b01) ? longint'(m_lim) * 65536 : longint'(m_lim);
    rate   = !m_chg && ((m_mode == 2'b11) ||
             ((m_mode == 2'b01 || m_mode == 2'b10) && ((m_phase % (lim + 1)) == lim)));
    spulse = sh[sh.size()-1-SYNC] && !sh[sh.size()-2-SYNC];
    src    = (halted || m_mode == 2'b00) ? spulse : rate;
    tk = 0; dnow = 0; dpend_n = 0; n_run = m_run; n_bst = m_bst;
    if (ctl.iHalt || ctl.iBreak) begin
      tk = halted && spulse; n_run = 0; n_bst = 0; m_left = 0;
    end else if (ctl.iBurst) begin
      m_left = int'(ctl.iBurstLen); n_run = 0; n_bst = (m_left != 0); dnow = (m_left == 0);
    end else if (ctl.iRun && !m_run) begin
      n_run = 1; n_bst = 0; m_left = 0;
    end else begin
      tk = src;
      if (src && m_bst) begin
        m_left--;
        if (m_left == 0) begin n_bst = 0; dpend_n = 1; end
      end
    end
    if (m_chg || halted || m_mode == 2'b00 || m_mode == 2'b11) m_phase = 0;
    else m_phase++;
    m_chg  = (ctl.iMode != m_mode) || (ctl.iLimit != m_lim);
    m_mode = ctl.iMode;
    m_lim  = ctl.iLimit;
    m_done = dnow || m_dpend;
    m_dpend = dpend_n;
    m_tick = tk;
    m_count += 32'(tk);
    m_run = n_run; m_bst = n_bst;
    m_running = n_run || n_bst;
    sh.push_back(ctl.iStep);
    if (sh.size() > 16) void'(sh.pop_front());
  endfunction

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check("tick",    32'(ctl.oTick),    32'(m_tick));
    check("running", 32'(ctl.oRunning), 32'(m_running));
    check("done",    32'(ctl.oDone),    32'(m_done));
    check("count",   ctl.oTickCount,    m_count);
  endtask

  int first, n, prev_t, tick_at, done_at, saw, dseen;
  bit [31:0] base;

  initial begin
    ctl.iMode = 2'b00; ctl.iLimit = 8'd0; ctl.iStep = 1'b0; ctl.iRun = 1'b0;
    ctl.iBurst = 1'b0; ctl.iBurstLen = '0; ctl.iHalt = 1'b0; ctl.iBreak = 1'b0;
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    check("rst_tick", 32'(ctl.oTick), 0);
    check("rst_running", 32'(ctl.oRunning), 0);
    check("rst_count", ctl.oTickCount, 0);

    // Max rate free-run, then halt.
    ctl.iMode = 2'b11;
    repeat (2) cycle();
    ctl.iRun = 1'b1; cycle(); ctl.iRun = 1'b0;
    check("max_running", 32'(ctl.oRunning), 1);
    repeat (18) cycle();
    ctl.iHalt = 1'b1; cycle(); ctl.iHalt = 1'b0;
    check("max_halt_tick", 32'(ctl.oTick), 0);
    repeat (3) cycle();
    check("max_count", ctl.oTickCount, 18);

    // Fast, limit 3: period 4; then limit 0 mid-run.
    ctl.iMode = 2'b10; ctl.iLimit = 8'd3;
    repeat (2) cycle();
    ctl.iRun = 1'b1; cycle(); ctl.iRun = 1'b0;
    prev_t = -1;
    for (int i = 0; i < 17; i++) begin
      cycle();
      if (ctl.oTick) begin
        if (prev_t >= 0) check("fast_period", 32'(i - prev_t), 4);
        prev_t = i;
      end
    end
    ctl.iLimit = 8'd0;
    repeat (8) cycle();
    ctl.iHalt = 1'b1; cycle(); ctl.iHalt = 1'b0;

    // Slow, limit 1: one-tick burst lands 65537 cycles after start.
    ctl.iMode = 2'b01; ctl.iLimit = 8'd1;
    repeat (2) cycle();
    ctl.iBurst = 1'b1; ctl.iBurstLen = 16'd1; cycle(); ctl.iBurst = 1'b0;
    tick_at = -1; done_at = -1;
    for (int i = 0; i < 70000 && done_at < 0; i++) begin
      cycle();
      if (ctl.oTick) tick_at = i;
      if (ctl.oDone) done_at = i;
    end
    check("slow_tick_at", 32'(tick_at), 32'(1 << 16));
    check("slow_done_gap", 32'(done_at - tick_at), 1);
    check("slow_running", 32'(ctl.oRunning), 0);

    // Manual step presses while halted.
    ctl.iMode = 2'b00; ctl.iLimit = 8'd0;
    repeat (2) cycle();
    for (int r = 0; r < 2; r++) begin
      ctl.iStep = 1'b1; first = -1; n = 0;
      for (int i = 0; i < 16; i++) begin
        if (i == 10) ctl.iStep = 1'b0;
        cycle();
        if (ctl.oTick) begin n++; if (first < 0) first = i; end
      end
      check("step_count", 32'(n), 1);
      check("step_latency", 32'(first), 32'(SYNC + 1));
    end

    // Burst 100 at max rate, breakpoint after 40 ticks.
    ctl.iMode = 2'b11;
    repeat (2) cycle();
    base = m_count; dseen = 0;
    ctl.iBurst = 1'b1; ctl.iBurstLen = 16'd100; cycle(); ctl.iBurst = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && n < 40; i++) begin
      cycle();
      if (ctl.oTick) n++;
    end
    ctl.iBreak = 1'b1; cycle();
    check("brk_tick", 32'(ctl.oTick), 0);
    check("brk_count", ctl.oTickCount - base, 40);
    ctl.iRun = 1'b1; cycle(); ctl.iRun = 1'b0;
    cycle();
    check("brk_run_ignored", 32'(ctl.oRunning), 0);
    ctl.iStep = 1'b1; saw = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) ctl.iStep = 1'b0;
      cycle();
      if (ctl.oTick) saw++;
      if (ctl.oDone) dseen++;
    end
    check("brk_step", 32'(saw), 1);
    check("brk_no_done", 32'(dseen), 0);
    ctl.iBreak = 1'b0;
    cycle();

    // Counter wrap via preset.
    force dut.tick_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.tick_count_q;
    m_count = 32'hFFFF_FFFE;
    ctl.iBurst = 1'b1; ctl.iBurstLen = 16'd3; cycle(); ctl.iBurst = 1'b0;
    repeat (6) cycle();
    check("wrap_count", ctl.oTickCount, 32'h0000_0001);

    // Zero-length burst: done, no tick.
    ctl.iBurst = 1'b1; ctl.iBurstLen = 16'd0; cycle(); ctl.iBurst = 1'b0;
    check("zlen_done", 32'(ctl.oDone), 1);
    check("zlen_tick", 32'(ctl.oTick), 0);
    cycle();
    check("zlen_done_once", 32'(ctl.oDone), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 49) == 0) ctl.iMode  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) ctl.iLimit = 8'($urandom_range(0, 4));
      ctl.iRun      = ($urandom_range(0, 19) == 0);
      ctl.iBurst    = ($urandom_range(0, 29) == 0);
      ctl.iBurstLen = 16'($urandom_range(0, 12));
      ctl.iHalt     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) ctl.iBreak = ~ctl.iBreak;
      if ($urandom_range(0, 7) == 0)  ctl.iStep  = ~ctl.iStep;
      cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
